// File: rtl/dual_digit_scan_if.sv
// Bundle of the digit-loading inputs and the display/debug outputs of the
// two-digit multiplexed seven-segment scanner.
interface dual_digit_scan_if;
  logic       new_valid;
  logic [3:0] new_digit;
  logic       display_en;
  logic [3:0] s;
  logic [1:0] an;
  logic [3:0] d_left;
  logic [3:0] d_right;

  // The master side loads digits and gates the display.
  modport master (
    output new_valid, new_digit, display_en,
    input  s, an, d_left, d_right
  );

  // The slave side is the scanner itself.
  modport slave (
    input  new_valid, new_digit, display_en,
    output s, an, d_left, d_right
  );
endinterface

// File: rtl/dual_digit_scan.sv
// Two-digit scanner that time-shares one sevenSeg decoder.
// Each digit is lit for REFRESH_CYCLES, separated by BLANK_CYCLES of
// darkness so the decoder output settles before the next enable.
module dual_digit_scan #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 16
) (
  input logic             clk,
  input logic             reset,
  dual_digit_scan_if.slave bus
);

  localparam int CNT_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_R  = 2'd0,
    BLANK_R = 2'd1,
    SHOW_L  = 2'd2,
    BLANK_L = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       d_left;
  logic [3:0]       d_right;
  logic             en_q;
  logic [1:0]       an;
  logic [3:0]       s;

  // Scan state and slot counter; reset restarts the scan at the right digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW_R;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Count through the current slot, then step to the next slot with cnt cleared.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    unique case (state)
      SHOW_R:  if (cnt == SHOW_LAST)  begin state_next = BLANK_R; cnt_next = '0; end
      BLANK_R: if (cnt == BLANK_LAST) begin state_next = SHOW_L;  cnt_next = '0; end
      SHOW_L:  if (cnt == SHOW_LAST)  begin state_next = BLANK_L; cnt_next = '0; end
      BLANK_L: if (cnt == BLANK_LAST) begin state_next = SHOW_R;  cnt_next = '0; end
      default: begin state_next = SHOW_R; cnt_next = '0; end
    endcase
  end

  // Digits shift in from the right; reset wins over a coincident load.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_left  <= 4'h0;
      d_right <= 4'h0;
    end else if (bus.new_valid) begin
      d_left  <= d_right;
      d_right <= bus.new_digit;
    end
  end

  // Display enable is registered so the outputs depend on flops only; it is
  // sampled even during reset so the first post-reset cycle is already lit.
  always_ff @(posedge clk) begin
    en_q <= bus.display_en;
  end

  // Drive the digit enables and the shared decoder value from registered state.
  always_comb begin
    an = 2'b11;
    s  = d_right;
    unique case (state)
      SHOW_R:  begin an = 2'b10; s = d_right; end
      BLANK_R: begin an = 2'b11; s = d_right; end
      SHOW_L:  begin an = 2'b01; s = d_left;  end
      BLANK_L: begin an = 2'b11; s = d_left;  end
      default: begin an = 2'b11; s = d_right; end
    endcase
    if (!en_q) an = 2'b11;
  end

  assign bus.an      = an;
  assign bus.s       = s;
  assign bus.d_left  = d_left;
  assign bus.d_right = d_right;

endmodule

// File: tb/tb_dual_digit_scan.sv
// Self-checking bench for dual_digit_scan with short slot lengths.
module tb_dual_digit_scan;

  localparam int R      = 4;
  localparam int B      = 2;
  localparam int PERIOD = 2 * (R + B);

  logic clk;
  logic reset;
  dual_digit_scan_if bus ();

  dual_digit_scan #(
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES  (B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the scan period plus the two stored digits.
  int         t;
  logic [3:0] m_left;
  logic [3:0] m_right;
  logic       m_en;
  int         n_vec;
  int         n_err;
  int         step;

  // Expected digit enables derived from the position in the scan period.
  function automatic logic [1:0] exp_an();
    if (!m_en)              return 2'b11;
    if (t < R)              return 2'b10;
    if (t < R + B)          return 2'b11;
    if (t < 2 * R + B)      return 2'b01;
    return 2'b11;
  endfunction

  // Right digit owns the decoder for the first half of the period, left for the second.
  function automatic logic [3:0] exp_s();
    return (t < R + B) ? m_right : m_left;
  endfunction

  // Compare every observable output against the model.
  task automatic checkOutput();
    logic [1:0] ea;
    logic [3:0] es;
    ea = exp_an();
    es = exp_s();
    n_vec++;
    assert (bus.an === ea) else begin
      n_err++;
      $error("[TB] FAIL an step=%0d t=%0d observed=%b expected=%b", step, t, bus.an, ea);
    end
    n_vec++;
    assert (bus.s === es) else begin
      n_err++;
      $error("[TB] FAIL s step=%0d t=%0d observed=%h expected=%h", step, t, bus.s, es);
    end
    n_vec++;
    assert (bus.d_left === m_left) else begin
      n_err++;
      $error("[TB] FAIL d_left step=%0d observed=%h expected=%h", step, bus.d_left, m_left);
    end
    n_vec++;
    assert (bus.d_right === m_right) else begin
      n_err++;
      $error("[TB] FAIL d_right step=%0d observed=%h expected=%h", step, bus.d_right, m_right);
    end
    n_vec++;
    assert (bus.an !== 2'b00) else begin
      n_err++;
      $error("[TB] FAIL an_both_low step=%0d observed=%b expected=not 00", step, bus.an);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input logic rst, input logic nv, input logic [3:0] nd, input logic en);
    reset          = rst;
    bus.new_valid  = nv;
    bus.new_digit  = nd;
    bus.display_en = en;
    @(posedge clk);
    if (rst) begin
      t       = 0;
      m_left  = 4'h0;
      m_right = 4'h0;
    end else begin
      t = (t + 1) % PERIOD;
      if (nv) begin
        m_left  = m_right;
        m_right = nd;
      end
    end
    m_en = en;
    @(negedge clk);
    step++;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  // Idle until the model sits at the requested position in the period.
  task automatic alignTo(input int target);
    for (int i = 0; i < PERIOD && t != target; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    n_vec = 0;
    n_err = 0;
    step  = 0;
    t     = 0;
    m_left  = 4'h0;
    m_right = 4'h0;
    m_en    = 1'b1;
    reset          = 1'b1;
    bus.new_valid  = 1'b0;
    bus.new_digit  = 4'h0;
    bus.display_en = 1'b1;

    $display("[TB] reset and free-run");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'h5, 1'b1);
    idleCycles(2 * PERIOD);

    $display("[TB] load 3 then F");
    applyStimulus(1'b0, 1'b1, 4'h3, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1);
    idleCycles(PERIOD);

    $display("[TB] load on the edge ending SHOW_R");
    alignTo(R - 1);
    applyStimulus(1'b0, 1'b1, 4'h8, 1'b1);
    idleCycles(3);

    $display("[TB] display disabled mid SHOW_L");
    alignTo(R + B + 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    idleCycles(PERIOD);

    $display("[TB] reset in BLANK_L with a coincident load");
    applyStimulus(1'b0, 1'b1, 4'h6, 1'b1);
    alignTo(2 * R + B);
    applyStimulus(1'b1, 1'b1, 4'hA, 1'b1);
    idleCycles(3);

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) != 0));
    end
    idleCycles(PERIOD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
